// File: rtl/screen_pkg.sv
// Shared definitions for the pixel-to-normalised-coordinate inverse mapper:
// widths, the coordinate origin, FSM state type and the quotient-to-coordinate helper.
package screen_pkg;

    localparam logic [7:0] ORIGIN = 8'h7F;
    localparam int         QW     = 9;
    localparam int         NW     = 25;
    localparam int         CW     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // A 9-bit quotient above 255 clamps to 255 before the origin shift.
    function automatic logic [7:0] to_coord(input logic [QW-1:0] u);
        logic [7:0] sat;
        sat = u[QW-1] ? 8'hFF : u[7:0];
        return sat - ORIGIN;
    endfunction

endpackage

// File: rtl/pix_div.sv
// Bit-serial restoring divider producing a 9-bit quotient MSB first,
// one quotient bit per step, against a fixed divisor R.
module pix_div
    import screen_pkg::*;
#(
    parameter int unsigned R = 320
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [NW-1:0] i_num,
    output logic [QW-1:0] o_quot
);

    // The quotient never exceeds 9 bits, so the divisor starts at R<<8 and
    // walks down one position per step instead of shifting the numerator in.
    localparam logic [NW-1:0] DIV_INIT = NW'(R * 32'd256);

    logic [NW-1:0] r_rem;
    logic [NW-1:0] r_dsh;
    logic [7:0]    r_quot;
    logic          w_ge;
    logic [NW-1:0] w_diff;

    assign w_ge   = (r_rem >= r_dsh);
    assign w_diff = r_rem - r_dsh;
    // Quotient including the bit decided by the current step.
    assign o_quot = {r_quot, w_ge};

    // Partial remainder, shifted divisor and accumulated quotient bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem  <= {NW{1'b0}};
            r_dsh  <= {NW{1'b0}};
            r_quot <= 8'h00;
        end else if (i_load) begin
            r_rem  <= i_num;
            r_dsh  <= DIV_INIT;
            r_quot <= 8'h00;
        end else if (i_step) begin
            r_rem  <= w_ge ? w_diff : r_rem;
            r_dsh  <= r_dsh >> 1;
            r_quot <= o_quot[7:0];
        end else begin
            r_rem  <= r_rem;
            r_dsh  <= r_dsh;
            r_quot <= r_quot;
        end
    end

endmodule

// File: rtl/from_screen.sv
// Converts a pixel position back into signed 8-bit normalised coordinates
// using two parallel bit-serial dividers behind valid/ready handshakes.
module from_screen
    import screen_pkg::*;
#(
    parameter int unsigned X_RESOL = 320,
    parameter int unsigned Y_RESOL = 200
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        ENB,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [15:0] Xpix,
    input  logic [15:0] Ypix,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [7:0]  Xcoord,
    output logic [7:0]  Ycoord,
    output logic        ERR
);

    localparam logic [NW-1:0] X_HALF = NW'(X_RESOL / 32'd2);
    localparam logic [NW-1:0] Y_HALF = NW'(Y_RESOL / 32'd2);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [7:0]      r_x;
    logic [7:0]      r_y;
    logic            r_err;

    logic [NW-1:0]   w_x_num;
    logic [NW-1:0]   w_y_num;
    logic            w_oor;
    logic            w_load;
    logic            w_step;
    logic [QW-1:0]   w_qx;
    logic [QW-1:0]   w_qy;

    // Numerator p*256 + floor(R/2) gives a round-to-nearest quotient.
    assign w_x_num = {1'b0, Xpix, 8'h00} + X_HALF;
    assign w_y_num = {1'b0, Ypix, 8'h00} + Y_HALF;
    assign w_oor   = ({16'h0000, Xpix} >= 32'(X_RESOL)) || ({16'h0000, Ypix} >= 32'(Y_RESOL));
    assign w_load  = ENB && (r_state == IDLE) && IN_VALID && !w_oor;
    assign w_step  = ENB && (r_state == CALC);

    pix_div #(.R(X_RESOL)) u_div_x (
        .i_clk   (ACLK),
        .i_rst_n (ARESETN),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_num   (w_x_num),
        .o_quot  (w_qx)
    );

    pix_div #(.R(Y_RESOL)) u_div_y (
        .i_clk   (ACLK),
        .i_rst_n (ARESETN),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_num   (w_y_num),
        .o_quot  (w_qy)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_x         <= 8'h00;
            r_y         <= 8'h00;
            r_err       <= 1'b0;
        end else if (ENB) begin
            case (r_state)
                IDLE: begin
                    if (IN_VALID) begin
                        r_in_ready <= 1'b0;
                        if (w_oor) begin
                            r_x         <= 8'h00;
                            r_y         <= 8'h00;
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_cnt   <= 4'd8;
                            r_err   <= 1'b0;
                            r_state <= CALC;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                CALC: begin
                    if (r_cnt == 4'd0) begin
                        r_x         <= to_coord(w_qx);
                        r_y         <= to_coord(w_qy);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end else begin
            r_state <= r_state;
        end
    end

    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_out_valid;
    assign Xcoord    = r_x;
    assign Ycoord    = r_y;
    assign ERR       = r_err;

endmodule

// File: tb/tb_from_screen.sv
// Scoreboard bench for from_screen: requests push expected results computed
// from plain integer arithmetic; a monitor pops and compares on each transfer.
module tb_from_screen;

    localparam int XR = 320;
    localparam int YR = 200;

    logic        ACLK      = 1'b0;
    logic        ARESETN   = 1'b0;
    logic        ENB       = 1'b1;
    logic        IN_VALID  = 1'b0;
    logic        OUT_READY = 1'b1;
    logic [15:0] Xpix      = 16'd0;
    logic [15:0] Ypix      = 16'd0;
    logic        IN_READY;
    logic        OUT_VALID;
    logic [7:0]  Xcoord;
    logic [7:0]  Ycoord;
    logic        ERR;

    typedef struct {
        logic       err;
        logic [7:0] xc;
        logic [7:0] yc;
        int         xp;
        int         yp;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   rdy_rand  = 1'b0;
    bit   enb_rand  = 1'b0;
    logic fixed_rdy = 1'b1;
    logic fixed_enb = 1'b1;

    from_screen #(.X_RESOL(XR), .Y_RESOL(YR)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .ENB       (ENB),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .Xpix      (Xpix),
        .Ypix      (Ypix),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Xcoord    (Xcoord),
        .Ycoord    (Ycoord),
        .ERR       (ERR)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_coord(input int p, input int r);
        int u;
        u = (p * 256 + r / 2) / r;
        if (u > 255) u = 255;
        return 8'((u + 256 - 127) % 256);
    endfunction

    function automatic exp_t expect_of(input int x, input int y);
        exp_t e;
        e.xp  = x;
        e.yp  = y;
        e.err = (x >= XR) || (y >= YR);
        e.xc  = e.err ? 8'h00 : ref_coord(x, XR);
        e.yc  = e.err ? 8'h00 : ref_coord(y, YR);
        return e;
    endfunction

    // Handshake-side drivers: consumer ready and clock enable.
    initial begin
        forever begin
            @(negedge ACLK);
            OUT_READY = rdy_rand ? ($urandom_range(0, 3) != 0) : fixed_rdy;
            ENB       = enb_rand ? ($urandom_range(0, 7) != 0) : fixed_enb;
        end
    end

    // Monitor: every completed output transfer is checked against the queue.
    initial begin
        exp_t e;
        int   ux, uy, px, py;
        forever begin
            @(negedge ACLK);
            #1;
            if (ARESETN && OUT_VALID && OUT_READY && ENB) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got result x=%0h y=%0h err=%0b, expected none", Xcoord, Ycoord, ERR);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("err(%0d,%0d)", e.xp, e.yp), int'(ERR), int'(e.err));
                    chk($sformatf("xcoord(%0d,%0d)", e.xp, e.yp), int'(Xcoord), int'(e.xc));
                    chk($sformatf("ycoord(%0d,%0d)", e.xp, e.yp), int'(Ycoord), int'(e.yc));
                    if (!e.err) begin
                        ux = (int'(Xcoord) + 127) % 256;
                        uy = (int'(Ycoord) + 127) % 256;
                        px = (ux * XR) / 256;
                        py = (uy * YR + 128) / 256;
                        n_tests++;
                        if (!(px == e.xp || px == e.xp - 1)) begin
                            n_fail++;
                            $display("FAIL roundtrip_x: got %0d, expected %0d or %0d", px, e.xp, e.xp - 1);
                        end
                        chk($sformatf("roundtrip_y(%0d)", e.yp), py, e.yp);
                    end
                end
            end
        end
    end

    task automatic send(input int x, input int y, input bit push);
        bit ok;
        @(negedge ACLK);
        IN_VALID = 1'b1;
        Xpix     = 16'(x);
        Ypix     = 16'(y);
        ok       = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            #1;
            if (IN_READY && ENB) ok = 1'b1;
            else @(negedge ACLK);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept, expected accept of (%0d,%0d)", x, y);
        end
        if (push && ok) q.push_back(expect_of(x, y));
        @(posedge ACLK);
        #1;
        IN_VALID = 1'b0;
        Xpix     = 16'($urandom);
        Ypix     = 16'($urandom);
    endtask

    task automatic latency(input int exp_lat, input bit drop_enb, input string nm);
        int n;
        n = 0;
        while (!OUT_VALID && n < 100) begin
            @(posedge ACLK);
            #1;
            n++;
            if (drop_enb && n == 2) fixed_enb = 1'b0;
            if (drop_enb && n == 5) fixed_enb = 1'b1;
        end
        chk(nm, n, exp_lat);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50 && OUT_VALID; k++) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    initial begin
        logic [7:0] sx, sy;
        logic       se;
        bit         seen;

        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_in_ready", int'(IN_READY), 1);
        chk("rst_out_valid", int'(OUT_VALID), 0);
        chk("rst_xcoord", int'(Xcoord), 0);
        chk("rst_ycoord", int'(Ycoord), 0);
        chk("rst_err", int'(ERR), 0);
        @(negedge ACLK);
        ARESETN = 1'b1;

        // Reset two edges after accept discards the pending result.
        send(160, 100, 1'b0);
        repeat (2) @(posedge ACLK);
        #1;
        ARESETN = 1'b0;
        #1;
        chk("midcalc_out_valid", int'(OUT_VALID), 0);
        chk("midcalc_in_ready", int'(IN_READY), 1);
        chk("midcalc_xcoord", int'(Xcoord), 0);
        chk("midcalc_ycoord", int'(Ycoord), 0);
        chk("midcalc_err", int'(ERR), 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge ACLK);
            #1;
            if (OUT_VALID) seen = 1'b1;
        end
        chk("midcalc_no_result", int'(seen), 0);

        // Centre point under backpressure with ignored input pulses.
        fixed_rdy = 1'b0;
        send(160, 100, 1'b1);
        latency(9, 1'b0, "lat_centre");
        sx = Xcoord;
        sy = Ycoord;
        se = ERR;
        for (int i = 0; i < 5; i++) begin
            @(posedge ACLK);
            #1;
            chk("hold_stable", int'({OUT_VALID, IN_READY, ERR, Xcoord, Ycoord}),
                int'({1'b1, 1'b0, se, sx, sy}));
            IN_VALID = 1'b1;
            Xpix     = 16'($urandom_range(0, 319));
            Ypix     = 16'($urandom_range(0, 199));
        end
        IN_VALID  = 1'b0;
        fixed_rdy = 1'b1;
        wait_idle();

        send(0, 0, 1'b1);
        latency(12, 1'b1, "lat_enb_drop");
        wait_idle();
        send(320, 5, 1'b1);
        latency(0, 1'b0, "lat_oor_x");
        wait_idle();
        send(5, 200, 1'b1);
        latency(0, 1'b0, "lat_oor_y");
        wait_idle();
        send(319, 199, 1'b1);
        latency(9, 1'b0, "lat_corner");
        wait_idle();

        // Full X sweep (Y cycles through every row) then random requests.
        rdy_rand = 1'b1;
        enb_rand = 1'b1;
        for (int i = 0; i < XR; i++) send(i, i % YR, 1'b1);
        for (int i = 0; i < 40; i++) send($urandom_range(0, 340), $urandom_range(0, 220), 1'b1);
        rdy_rand = 1'b0;
        enb_rand = 1'b0;
        for (int k = 0; k < 500 && q.size() != 0; k++) begin
            @(posedge ACLK);
            #1;
        end
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/from_screen.md
Name: from_screen

Overview:
- Inverse of the screen-mapping stage: converts a pixel position (Xpix, Ypix) back into the signed 8-bit normalised coordinates (Xcoord, Ycoord) used by the geometry pipeline.
- Used for picking/cursor feedback and for readback of rendered points.
- Sequential: two bit-serial restoring dividers run in parallel.
- Valid/ready handshake on both sides.

Parameters:
- X_RESOL, 320, horizontal resolution in pixels. Legal range 2..65535.
- Y_RESOL, 200, vertical resolution in pixels. Legal range 2..65535.

Ports:
- ACLK  in  1  clock; all state updates on the rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- ENB  in  1  clock enable; when low, all state and outputs hold.
- IN_VALID  in  1  Xpix/Ypix valid.
- IN_READY  out  1  block can accept a request.
- Xpix  in  16  pixel column, unsigned.
- Ypix  in  16  pixel row, unsigned.
- OUT_VALID  out  1  result valid; held until accepted.
- OUT_READY  in  1  consumer accepts the result.
- Xcoord  out  8  normalised X, two's complement.
- Ycoord  out  8  normalised Y, two's complement.
- ERR  out  1  request was out of range; Xcoord/Ycoord are 0.

Behaviour:
- Reset (async, ARESETN=0): state=IDLE, IN_READY=1, OUT_VALID=0, Xcoord=0, Ycoord=0, ERR=0, counter=0.
- Arithmetic, per axis with R = X_RESOL or Y_RESOL and p = pixel:
  - N = p*256 + floor(R/2), 25 bits unsigned.
  - u = floor(N/R), 9-bit quotient.
  - If u > 255, saturate u to 255.
  - coord = (u - 8'h7F) mod 256.
  - Rounded inverse: re-mapping coord through the forward screen map gives p or p-1; exact for the R <= 256 axis.
- Range check at accept: if Xpix >= X_RESOL or Ypix >= Y_RESOL, the request is out of range. It produces Xcoord=0, Ycoord=0, ERR=1 and no division is run.
- FSM states: IDLE, CALC, DONE. Transitions happen only on edges with ENB=1.
- IDLE:
  - IN_READY=1.
  - On IN_VALID=1 (accept edge), latch both numerators and clear the partial remainders.
  - If out of range, go to DONE with ERR=1.
  - Otherwise set counter=8, ERR=0, and go to CALC.
- CALC:
  - IN_READY=0.
  - Each edge performs one restoring step per axis, MSB first, on quotient bits 8..0. Both axes share the counter.
  - On the edge with counter=0, load the final Xcoord/Ycoord and go to DONE.
  - OUT_VALID is high after the 9th edge following the accept edge.
- DONE:
  - OUT_VALID=1, IN_READY=0.
  - Xcoord/Ycoord/ERR are stable while OUT_VALID=1 and OUT_READY=0.
  - On OUT_READY=1, go to IDLE and clear OUT_VALID.
  - IN_READY returns to 1 on the next cycle; there is no same-cycle re-accept.
- Throughput: one request per 11 cycles in range with zero backpressure, and per 2 cycles for out-of-range requests.
- ENB=0: FSM, counter, dividers and outputs freeze. Handshake inputs are ignored on those edges.
- Reset asserted mid-CALC or mid-DONE: immediate return to reset values. The pending result is discarded and no OUT_VALID pulse is produced.
- Xpix/Ypix changing after the accept edge: no effect, because the inputs are latched.

Decomposition:
- Shared package (screen_pkg):
  - ORIGIN = 8'h7F.
  - Quotient width 9 and numerator width 25.
  - FSM state typedef {IDLE, CALC, DONE}.
- Sub-module pix_div:
  - One bit-serial restoring divider, parameterised by divisor R.
  - Ports: load, step, numerator in, 9-bit quotient out.
  - Instantiated twice, once per axis; the top holds the FSM, counter, range check and output registers.

Test Plan:
- Reset mid-CALC: accept (160,100), assert ARESETN=0 two edges later -> OUT_VALID=0, IN_READY=1, outputs 0; no result appears after release.
- Centre: Xpix=160, Ypix=100 -> after 9 edges: Xcoord=8'h01, Ycoord=8'h01, ERR=0.
- Corners:
  - (0,0) -> Xcoord=8'h81, Ycoord=8'h81.
  - (319,199) -> Xcoord=8'h80, Ycoord=8'h80.
- Out of range: Xpix=320, Ypix=5 -> OUT_VALID on the next edge, ERR=1, Xcoord=Ycoord=0.
- Backpressure and ENB:
  - Hold OUT_READY=0 for 5 cycles -> outputs stable; IN_VALID pulses during that time are ignored.
  - Drop ENB for 3 cycles in CALC -> latency extends by exactly 3 cycles.
- Round trip: sweep all Xpix 0..319 and Ypix 0..199 through from_screen and then the forward map -> re-mapped pixel is p or p-1; Y axis exact.
